// File: rtl/level_processor.sv
// Level processor: samples level_raw on each clk_1kHz rise, converts it to BCD and flags GOET/LOET; ALARM_FILTER_EN adds consecutive-sample alarm qualification.
// Latency: outputs and the sample_done pulse appear 11 clk_100MHz cycles after the cycle in which the rising edge is detected.
// Backpressure: none; rising edges that arrive while a conversion is in flight are dropped, not queued.
module level_processor #(
  parameter logic [9:0]  HIGH_LIMIT  = 10'd800,
  parameter logic [9:0]  LOW_LIMIT   = 10'd200,
  parameter int unsigned ALARM_COUNT = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       clk_1kHz,
  input  logic [9:0] level_raw,
  output logic [3:0] data_h,
  output logic [3:0] data_t,
  output logic [3:0] data_u,
  output logic       input_error,
  output logic       GOET,
  output logic       LOET,
  output logic       sample_done
);

  if (LOW_LIMIT >= HIGH_LIMIT) begin : g_bad_limits
    $error("level_processor: LOW_LIMIT must be below HIGH_LIMIT");
  end
  if (HIGH_LIMIT > 10'd999) begin : g_bad_high
    $error("level_processor: HIGH_LIMIT must be in 0..999");
  end
  if (ALARM_COUNT < 1 || ALARM_COUNT > 15) begin : g_bad_count
    $error("level_processor: ALARM_COUNT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t      state;
  logic        clk_1khz_q;
  logic        sample_edge;
  logic [9:0]  shadow;
  logic [9:0]  shift_reg;
  logic [11:0] bcd;
  logic [11:0] bcd_next;
  logic [3:0]  bit_cnt;
  logic        is_err;
  logic        hi_qual;
  logic        lo_qual;
  logic        goet_next;
  logic        loet_next;

`ifdef ALARM_FILTER_EN
  localparam logic [3:0] ALARM_CNT = 4'(ALARM_COUNT);
  logic [3:0] hi_cnt;
  logic [3:0] lo_cnt;
  logic [3:0] hi_cnt_next;
  logic [3:0] lo_cnt_next;
`endif

  // One double-dabble step: correct every digit that would overflow past 9, then shift in the next binary bit.
  function automatic logic [11:0] bcd_step(input logic [11:0] b, input logic bit_in);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[10:0], bit_in};
  endfunction

  always_comb begin
    sample_edge = clk_1kHz && !clk_1khz_q;
    bcd_next    = bcd_step(bcd, shift_reg[9]);
    is_err      = (shadow > 10'd999);
    hi_qual     = !is_err && (shadow >= HIGH_LIMIT);
    lo_qual     = !is_err && (shadow <= LOW_LIMIT);
`ifdef ALARM_FILTER_EN
    hi_cnt_next = '0;
    lo_cnt_next = '0;
    if (hi_qual) hi_cnt_next = (hi_cnt >= ALARM_CNT) ? ALARM_CNT : hi_cnt + 4'd1;
    if (lo_qual) lo_cnt_next = (lo_cnt >= ALARM_CNT) ? ALARM_CNT : lo_cnt + 4'd1;
    goet_next = (hi_cnt_next == ALARM_CNT);
    loet_next = (lo_cnt_next == ALARM_CNT);
`else
    goet_next = hi_qual;
    loet_next = lo_qual;
`endif
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      clk_1khz_q  <= 1'b1;
      shadow      <= '0;
      shift_reg   <= '0;
      bcd         <= '0;
      bit_cnt     <= '0;
      data_h      <= '0;
      data_t      <= '0;
      data_u      <= '0;
      input_error <= 1'b0;
      GOET        <= 1'b0;
      LOET        <= 1'b0;
      sample_done <= 1'b0;
`ifdef ALARM_FILTER_EN
      hi_cnt      <= '0;
      lo_cnt      <= '0;
`endif
    end else begin
      clk_1khz_q  <= clk_1kHz;
      sample_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_edge) begin
            shadow    <= level_raw;
            shift_reg <= level_raw;
            bcd       <= '0;
            bit_cnt   <= '0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          bcd       <= bcd_next;
          shift_reg <= {shift_reg[8:0], 1'b0};
          bit_cnt   <= bit_cnt + 4'd1;
          // The last shift lands straight in the outputs so they are visible for the whole UPDATE cycle.
          if (bit_cnt == 4'd9) begin
            state       <= UPDATE;
            sample_done <= 1'b1;
            input_error <= is_err;
            GOET        <= goet_next;
            LOET        <= loet_next;
            if (!is_err) begin
              data_h <= bcd_next[11:8];
              data_t <= bcd_next[7:4];
              data_u <= bcd_next[3:0];
            end
`ifdef ALARM_FILTER_EN
            hi_cnt <= hi_cnt_next;
            lo_cnt <= lo_cnt_next;
`endif
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_level_processor.sv
// Bench for level_processor: randomized and directed samples against a scoreboard fed by an arithmetic reference model.
module tb_level_processor;

  localparam logic [9:0]  HIGH = 10'd800;
  localparam logic [9:0]  LOW  = 10'd200;
  localparam int unsigned AC   = 4;

  logic       clk_100MHz = 1'b0;
  logic       reset_n;
  logic       clk_1kHz;
  logic [9:0] level_raw;
  logic [3:0] data_h, data_t, data_u;
  logic       input_error, GOET, LOET, sample_done;

  level_processor #(.HIGH_LIMIT(HIGH), .LOW_LIMIT(LOW), .ALARM_COUNT(AC)) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .clk_1kHz   (clk_1kHz),
    .level_raw  (level_raw),
    .data_h     (data_h),
    .data_t     (data_t),
    .data_u     (data_u),
    .input_error(input_error),
    .GOET       (GOET),
    .LOET       (LOET),
    .sample_done(sample_done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic [3:0]  h, t, u;
    logic        err, goet, loet;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [14:0] last;
  logic [31:0] cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;

  // Reference model state: last valid reading and run lengths of qualifying samples.
  int m_prev = 0;
  int m_hrun = 0;
  int m_lrun = 0;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic model_reset();
    m_prev = 0;
    m_hrun = 0;
    m_lrun = 0;
  endtask

  task automatic model_step(input int v, output exp_t e);
    bit err, hq, lq;
    err = (v > 999);
    if (!err) m_prev = v;
    hq = !err && (v >= int'(HIGH));
    lq = !err && (v <= int'(LOW));
    m_hrun = hq ? m_hrun + 1 : 0;
    m_lrun = lq ? m_lrun + 1 : 0;
    e.h   = 4'(m_prev / 100);
    e.t   = 4'((m_prev / 10) % 10);
    e.u   = 4'(m_prev % 10);
    e.err = err;
`ifdef ALARM_FILTER_EN
    e.goet = (m_hrun >= int'(AC));
    e.loet = (m_lrun >= int'(AC));
`else
    e.goet = hq;
    e.loet = lq;
`endif
    e.cyc = 0;
  endtask

  // Called just after a clock edge with clk_1kHz low for at least one cycle.
  task automatic do_sample(input logic [9:0] v);
    exp_t e;
    level_raw = v;
    clk_1kHz  = 1'b1;
    model_step(int'(v), e);
    e.cyc = cyc + 11;
    sb.push_back(e);
    wait_cyc(1);
    level_raw = 10'($urandom);
    wait_cyc(2);
    clk_1kHz = 1'b0;
    wait_cyc(11 + $urandom_range(0, 3));
  endtask

  always @(negedge clk_100MHz) begin
    if (reset_n) begin
      if (sample_done) begin
        n_done++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_sample_done: got pulse, required none (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          check("latency", cyc, mon_e.cyc);
          check("data_h", data_h, mon_e.h);
          check("data_t", data_t, mon_e.t);
          check("data_u", data_u, mon_e.u);
          check("input_error", input_error, mon_e.err);
          check("GOET", GOET, mon_e.goet);
          check("LOET", LOET, mon_e.loet);
          last = {mon_e.h, mon_e.t, mon_e.u, mon_e.err, mon_e.goet, mon_e.loet};
        end
      end else begin
        check("outputs_stable", {data_h, data_t, data_u, input_error, GOET, LOET}, last);
      end
    end
  end

  logic [9:0] corner [12] = '{10'd0, 10'd199, 10'd200, 10'd201, 10'd799, 10'd800,
                              10'd801, 10'd999, 10'd1000, 10'd1023, 10'd573, 10'd850};

  initial begin
    int base;
    exp_t e;
    reset_n   = 1'b0;
    clk_1kHz  = 1'b0;
    level_raw = '0;
    last      = '0;
    model_reset();
    #1;
    check("reset_outputs", {data_h, data_t, data_u, input_error, GOET, LOET, sample_done}, 0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(2);

    do_sample(10'd573);
    do_sample(10'd999);
    do_sample(10'd1000);
    do_sample(10'd800);
    do_sample(10'd200);
    do_sample(10'd201);
    for (int i = 0; i < 4; i++) do_sample(10'd850);
    do_sample(10'd700);
    for (int i = 0; i < 5; i++) do_sample(10'd150);
    do_sample(10'd1023);

    // Edges re-triggered mid-conversion must not start a second sample.
    base      = n_done;
    level_raw = 10'($urandom_range(0, 999));
    clk_1kHz  = 1'b1;
    model_step(int'(level_raw), e);
    e.cyc = cyc + 11;
    sb.push_back(e);
    wait_cyc(2);
    clk_1kHz = 1'b0;
    wait_cyc(2);
    clk_1kHz = 1'b1;
    wait_cyc(2);
    clk_1kHz = 1'b0;
    wait_cyc(14);
    check("glitch_single_sample", n_done - base, 1);

    // Reset in the fifth conversion cycle, released with clk_1kHz still high.
    do_sample(10'd999);
    level_raw = 10'd500;
    clk_1kHz  = 1'b1;
    wait_cyc(5);
    reset_n = 1'b0;
    sb.delete();
    last = '0;
    model_reset();
    #1;
    check("abort_outputs", {data_h, data_t, data_u, input_error, GOET, LOET, sample_done}, 0);
    wait_cyc(3);
    reset_n = 1'b1;
    base = n_done;
    wait_cyc(20);
    check("no_sample_after_reset", n_done - base, 0);
    clk_1kHz = 1'b0;
    wait_cyc(2);
    do_sample(10'd42);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) do_sample(corner[$urandom_range(0, 11)]);
      else do_sample(10'($urandom_range(0, 1023)));
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) wait_cyc(1);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
